// File: rtl/id_ex_operand_stage.sv
// ID/EX pipeline register with operand forwarding, load-use stall detection
// and a saturating stall counter for performance debug.
module id_ex_operand_stage #(
    parameter int DW = 32,
    parameter int AW = 5,
    parameter int CW = 16
) (
    input  logic          Clk,
    input  logic          Reset,
    input  logic [AW-1:0] IdRs,
    input  logic [AW-1:0] IdRt,
    input  logic [AW-1:0] IdRd,
    input  logic [DW-1:0] IdImm,
    input  logic [3:0]    IdAluOp,
    input  logic          IdAluSrc,
    input  logic          IdRegWrite,
    input  logic          IdMemRead,
    input  logic          IdMemWrite,
    input  logic          Flush,
    input  logic [DW-1:0] RegARdData,
    input  logic [DW-1:0] RegBRdData,
    input  logic          ExMemRegWrite,
    input  logic [AW-1:0] ExMemWrAddr,
    input  logic [DW-1:0] ExMemResult,
    input  logic          MemWbRegWrite,
    input  logic [AW-1:0] MemWbWrAddr,
    input  logic [DW-1:0] MemWbData,
    output logic          Stall,
    output logic [DW-1:0] OpA,
    output logic [DW-1:0] OpB,
    output logic [DW-1:0] StoreData,
    output logic [AW-1:0] ExRegWrAddr,
    output logic          ExRegWrite,
    output logic          ExMemRead,
    output logic          ExMemWrite,
    output logic [3:0]    ExAluOp,
    output logic [CW-1:0] StallCount
);

    logic [AW-1:0] rs_q, rt_q, rd_q;
    logic [DW-1:0] imm_q;
    logic          alu_src_q, reg_write_q, mem_read_q, mem_write_q;
    logic [3:0]    alu_op_q;
    logic [CW-1:0] stall_cnt_q, stall_cnt_d;
    logic          bubble;
    logic [DW-1:0] fwd_a, fwd_b;

    // Register $0 always reads zero, so it never forwards.
    function automatic logic [DW-1:0] forward(
        input logic [AW-1:0] addr,
        input logic [DW-1:0] rf_data,
        input logic          exmem_we,
        input logic [AW-1:0] exmem_addr,
        input logic [DW-1:0] exmem_data,
        input logic          memwb_we,
        input logic [AW-1:0] memwb_addr,
        input logic [DW-1:0] memwb_data
    );
        if (addr == '0)
            return '0;
        else if (exmem_we && exmem_addr == addr)
            return exmem_data;
        else if (memwb_we && memwb_addr == addr)
            return memwb_data;
        else
            return rf_data;
    endfunction

    assign Stall  = mem_read_q && (rd_q != '0) && ((rd_q == IdRs) || (rd_q == IdRt));
    assign bubble = Flush || Stall;

    always_ff @(posedge Clk) begin
        if (Reset || bubble) begin
            rs_q        <= '0;
            rt_q        <= '0;
            rd_q        <= '0;
            imm_q       <= '0;
            alu_src_q   <= 1'b0;
            reg_write_q <= 1'b0;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            alu_op_q    <= '0;
        end else begin
            rs_q        <= IdRs;
            rt_q        <= IdRt;
            rd_q        <= IdRd;
            imm_q       <= IdImm;
            alu_src_q   <= IdAluSrc;
            reg_write_q <= IdRegWrite;
            mem_read_q  <= IdMemRead;
            mem_write_q <= IdMemWrite;
            alu_op_q    <= IdAluOp;
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset)
            stall_cnt_q <= '0;
        else
            stall_cnt_q <= stall_cnt_d;
    end

    // Flush-only bubbles are deliberately not counted.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (Stall && (stall_cnt_q != {CW{1'b1}}))
            stall_cnt_d = stall_cnt_q + 1'b1;
    end

    assign fwd_a = forward(rs_q, RegARdData, ExMemRegWrite, ExMemWrAddr, ExMemResult,
                           MemWbRegWrite, MemWbWrAddr, MemWbData);
    assign fwd_b = forward(rt_q, RegBRdData, ExMemRegWrite, ExMemWrAddr, ExMemResult,
                           MemWbRegWrite, MemWbWrAddr, MemWbData);

    assign OpA         = fwd_a;
    assign OpB         = alu_src_q ? imm_q : fwd_b;
    assign StoreData   = fwd_b;
    assign ExRegWrAddr = rd_q;
    assign ExRegWrite  = reg_write_q;
    assign ExMemRead   = mem_read_q;
    assign ExMemWrite  = mem_write_q;
    assign ExAluOp     = alu_op_q;
    assign StallCount  = stall_cnt_q;

endmodule

// File: tb/tb_id_ex_operand_stage.sv
// Bench for id_ex_operand_stage: directed scenarios plus random traffic checked
// against an instruction-level model of the EX slot and stall counter.
module tb_id_ex_operand_stage;
    localparam int DW  = 32;
    localparam int AW  = 5;
    localparam int CW  = 4;
    localparam int SAT = (1 << CW) - 1;

    logic          clk, reset;
    logic [AW-1:0] id_rs, id_rt, id_rd;
    logic [DW-1:0] id_imm;
    logic [3:0]    id_alu_op;
    logic          id_alu_src, id_reg_write, id_mem_read, id_mem_write, flush;
    logic [DW-1:0] rf_a, rf_b;
    logic          exmem_we;
    logic [AW-1:0] exmem_addr;
    logic [DW-1:0] exmem_res;
    logic          memwb_we;
    logic [AW-1:0] memwb_addr;
    logic [DW-1:0] memwb_data;
    logic          stall;
    logic [DW-1:0] op_a, op_b, store_data;
    logic [AW-1:0] ex_rd;
    logic          ex_reg_write, ex_mem_read, ex_mem_write;
    logic [3:0]    ex_alu_op;
    logic [CW-1:0] stall_count;

    id_ex_operand_stage #(.DW(DW), .AW(AW), .CW(CW)) dut (
        .Clk(clk), .Reset(reset),
        .IdRs(id_rs), .IdRt(id_rt), .IdRd(id_rd), .IdImm(id_imm),
        .IdAluOp(id_alu_op), .IdAluSrc(id_alu_src), .IdRegWrite(id_reg_write),
        .IdMemRead(id_mem_read), .IdMemWrite(id_mem_write), .Flush(flush),
        .RegARdData(rf_a), .RegBRdData(rf_b),
        .ExMemRegWrite(exmem_we), .ExMemWrAddr(exmem_addr), .ExMemResult(exmem_res),
        .MemWbRegWrite(memwb_we), .MemWbWrAddr(memwb_addr), .MemWbData(memwb_data),
        .Stall(stall), .OpA(op_a), .OpB(op_b), .StoreData(store_data),
        .ExRegWrAddr(ex_rd), .ExRegWrite(ex_reg_write), .ExMemRead(ex_mem_read),
        .ExMemWrite(ex_mem_write), .ExAluOp(ex_alu_op), .StallCount(stall_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // The instruction currently sitting in EX, as the model sees it.
    typedef struct {
        int rs, rt, rd, imm, alu_op;
        bit alu_src, reg_write, mem_read, mem_write;
    } instr_t;

    instr_t m_ex, nop_instr;
    int     m_cnt;
    int     n_checks, n_pass, n_fail;
    bit     do_check;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic int ref_value(input int addr, input logic [31:0] rf);
        if (addr == 0) return 0;
        if (exmem_we && int'(exmem_addr) == addr) return int'(exmem_res);
        if (memwb_we && int'(memwb_addr) == addr) return int'(memwb_data);
        return int'(rf);
    endfunction

    function automatic bit ref_stall();
        return m_ex.mem_read && m_ex.rd != 0 &&
               (m_ex.rd == int'(id_rs) || m_ex.rd == int'(id_rt));
    endfunction

    task automatic settle_check();
        int a_val, b_val;
        #1;
        if (do_check) begin
            a_val = ref_value(m_ex.rs, rf_a);
            b_val = ref_value(m_ex.rt, rf_b);
            check("stall", 32'(stall), 32'(ref_stall()));
            check("op_a", op_a, a_val);
            check("op_b", op_b, m_ex.alu_src ? m_ex.imm : b_val);
            check("store_data", store_data, b_val);
            check("ex_rd", 32'(ex_rd), m_ex.rd);
            check("ex_reg_write", 32'(ex_reg_write), 32'(m_ex.reg_write));
            check("ex_mem_read", 32'(ex_mem_read), 32'(m_ex.mem_read));
            check("ex_mem_write", 32'(ex_mem_write), 32'(m_ex.mem_write));
            check("ex_alu_op", 32'(ex_alu_op), m_ex.alu_op);
            check("stall_count", 32'(stall_count), m_cnt);
        end
    endtask

    task automatic advance();
        bit s;
        s = ref_stall();
        if (reset) begin
            m_ex  = nop_instr;
            m_cnt = 0;
        end else begin
            if (s && m_cnt < SAT) m_cnt++;
            if (flush || s) m_ex = nop_instr;
            else begin
                m_ex.rs = int'(id_rs);          m_ex.rt = int'(id_rt);
                m_ex.rd = int'(id_rd);          m_ex.imm = int'(id_imm);
                m_ex.alu_op = int'(id_alu_op);  m_ex.alu_src = id_alu_src;
                m_ex.reg_write = id_reg_write;  m_ex.mem_read = id_mem_read;
                m_ex.mem_write = id_mem_write;
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic quiet();
        reset = 0; flush = 0;
        id_rs = 0; id_rt = 0; id_rd = 0; id_imm = 0; id_alu_op = 0;
        id_alu_src = 0; id_reg_write = 0; id_mem_read = 0; id_mem_write = 0;
        rf_a = 0; rf_b = 0;
        exmem_we = 0; exmem_addr = 0; exmem_res = 0;
        memwb_we = 0; memwb_addr = 0; memwb_data = 0;
    endtask

    task automatic rand_inputs(input int amax);
        id_rs = AW'($urandom_range(amax, 0));
        id_rt = AW'($urandom_range(amax, 0));
        id_rd = AW'($urandom_range(amax, 0));
        id_imm = $urandom;
        id_alu_op = 4'($urandom_range(15, 0));
        id_alu_src = 1'($urandom_range(1, 0));
        id_reg_write = 1'($urandom_range(1, 0));
        id_mem_read = ($urandom_range(2, 0) == 0);
        id_mem_write = 1'($urandom_range(1, 0));
        rf_a = $urandom;
        rf_b = $urandom;
        exmem_we = 1'($urandom_range(1, 0));
        exmem_addr = AW'($urandom_range(amax, 0));
        exmem_res = $urandom;
        memwb_we = 1'($urandom_range(1, 0));
        memwb_addr = AW'($urandom_range(amax, 0));
        memwb_data = $urandom;
    endtask

    initial begin
        nop_instr = '{default: 0};
        m_ex = nop_instr;
        m_cnt = 0;
        n_checks = 0; n_pass = 0; n_fail = 0;
        do_check = 0;
        quiet();
        @(negedge clk);

        // Reset for two cycles with random ID inputs.
        reset = 1; rand_inputs(31);
        settle_check(); advance();
        do_check = 1;
        rand_inputs(31); reset = 1;
        settle_check();
        check("rst_stall", 32'(stall), 0);
        check("rst_count", 32'(stall_count), 0);
        check("rst_op_a", op_a, 0);
        check("rst_ex_reg_write", 32'(ex_reg_write), 0);
        advance();
        quiet();

        // EX/MEM forward on Rs, register file value on Rt.
        id_rs = 3; id_rt = 4; id_rd = 5; id_reg_write = 1;
        settle_check(); advance();
        quiet();
        rf_a = 32'h11; rf_b = 32'h22;
        exmem_we = 1; exmem_addr = 3; exmem_res = 32'hAAAA0001;
        settle_check();
        check("exmem_fwd_op_a", op_a, 32'hAAAA0001);
        check("exmem_fwd_op_b", op_b, 32'h22);
        advance();

        // EX/MEM wins over MEM/WB; $0 never forwards.
        quiet(); id_rs = 5;
        settle_check(); advance();
        quiet();
        exmem_we = 1; exmem_addr = 5; exmem_res = 32'h1;
        memwb_we = 1; memwb_addr = 5; memwb_data = 32'h2;
        settle_check();
        check("prio_op_a", op_a, 32'h1);
        advance();
        quiet();
        settle_check(); advance();
        exmem_we = 1; exmem_addr = 0; exmem_res = 32'hFF;
        memwb_we = 1; memwb_addr = 0; memwb_data = 32'hEE; rf_a = 32'h1234;
        settle_check();
        check("zero_op_a", op_a, 32'h0);
        advance();

        // Load-use: lw $8 then add using $8.
        quiet(); id_rd = 8; id_rs = 1; id_mem_read = 1; id_reg_write = 1;
        settle_check(); advance();
        quiet(); id_rs = 8; id_rt = 2; id_rd = 9; id_reg_write = 1;
        settle_check();
        check("lu_stall", 32'(stall), 1);
        advance();
        settle_check();
        check("lu_stall_clear", 32'(stall), 0);
        check("lu_bubble_reg_write", 32'(ex_reg_write), 0);
        check("lu_count", 32'(stall_count), 1);
        advance();
        quiet(); memwb_we = 1; memwb_addr = 8; memwb_data = 32'hDEADBEEF;
        settle_check();
        check("lu_memwb_op_a", op_a, 32'hDEADBEEF);
        advance();

        // Flush squashes a writing store-like instruction without counting.
        quiet(); flush = 1; id_reg_write = 1; id_mem_write = 1; id_rd = 7;
        settle_check(); advance();
        quiet();
        settle_check();
        check("flush_reg_write", 32'(ex_reg_write), 0);
        check("flush_mem_write", 32'(ex_mem_write), 0);
        check("flush_count", 32'(stall_count), 1);
        advance();

        // Random traffic over a small register window to provoke hazards.
        for (int i = 0; i < 400; i++) begin
            rand_inputs(7);
            flush = ($urandom_range(7, 0) == 0);
            reset = ($urandom_range(49, 0) == 0);
            settle_check(); advance();
        end

        // Saturation: repeated load-use pairs, then reset mid-run.
        quiet(); reset = 1;
        settle_check(); advance();
        for (int i = 0; i < 20; i++) begin
            quiet(); id_rd = 8; id_mem_read = 1; id_reg_write = 1;
            settle_check(); advance();
            quiet(); id_rs = 8;
            settle_check(); advance();
        end
        quiet();
        settle_check();
        check("sat_count", 32'(stall_count), SAT);
        reset = 1;
        advance();
        reset = 0;
        settle_check();
        check("sat_reset_count", 32'(stall_count), 0);
        advance();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/id_ex_operand_stage.md
Name: id_ex_operand_stage

Overview:
ID/EX pipeline stage that sits directly downstream of the register file.
- Latches decoded ID-stage control, register addresses and immediate each cycle.
- Resolves final ALU operands by forwarding from EX/MEM and MEM/WB over the register file's registered read data.
- Detects load-use hazards and issues a one-cycle stall with bubble insertion.
- Keeps a saturating stall counter for performance debug.

Parameters:
- DW, 32, datapath width
- AW, 5, register address width
- CW, 16, stall counter width

Ports:
- Clk  in  1  clock; all state updates on rising edge
- Reset  in  1  synchronous, active-high reset
- IdRs  in  AW  Rs address of the ID-stage instruction (same value driven to register file port A)
- IdRt  in  AW  Rt address (same value driven to register file port B)
- IdRd  in  AW  destination address chosen by decode
- IdImm  in  DW  sign/zero-extended immediate
- IdAluOp  in  4  ALU operation code
- IdAluSrc  in  1  1 = operand B is the immediate
- IdRegWrite  in  1  instruction writes a register
- IdMemRead  in  1  instruction is a load
- IdMemWrite  in  1  instruction is a store
- Flush  in  1  branch/jump taken; squash the ID instruction
- RegARdData  in  DW  register file port A data, registered on the same edge this block latches Id*
- RegBRdData  in  DW  register file port B data
- ExMemRegWrite  in  1  EX/MEM stage writes a register
- ExMemWrAddr  in  AW  EX/MEM destination
- ExMemResult  in  DW  EX/MEM ALU result
- MemWbRegWrite  in  1  MEM/WB stage writes a register
- MemWbWrAddr  in  AW  MEM/WB destination
- MemWbData  in  DW  MEM/WB write-back data
- Stall  out  1  hold PC and IF/ID; combinational from EX state and Id* inputs
- OpA  out  DW  forwarded ALU operand A
- OpB  out  DW  ALU operand B (immediate or forwarded Rt)
- StoreData  out  DW  forwarded Rt value for stores
- ExRegWrAddr  out  AW  latched destination
- ExRegWrite  out  1  latched control
- ExMemRead  out  1  latched control
- ExMemWrite  out  1  latched control
- ExAluOp  out  4  latched control
- StallCount  out  CW  saturating count of stall cycles

Behaviour:
- Reset (sync, high): all Ex* outputs and latched Rs/Rt/Imm/AluSrc cleared to 0; StallCount = 0. Stall therefore reads 0 in the first cycle after reset. Reset has priority over Flush and Stall.
- Load-use hazard: Stall = ExMemRead & (ExRegWrAddr != 0) & ((ExRegWrAddr == IdRs) | (ExRegWrAddr == IdRt)).
- Rising edge, Flush = 1 or Stall = 1: insert a bubble.
  - ExRegWrite, ExMemRead, ExMemWrite, ExAluOp, ExRegWrAddr all = 0.
  - Latched Rs/Rt = 0, so no forwarding occurs for the bubble.
  - Flush and Stall together: a single bubble.
- Otherwise: latch all Id* fields. Latency is exactly 1 cycle from ID to EX outputs.
- During a stall, upstream holds Id* stable. The register file re-reads the same addresses, so RegA/BRdData are correct on re-latch. The load has then reached MEM/WB and is forwarded from there.
- Forwarding is combinational on latched Rs/Rt, evaluated per operand:
  - If addr == 0: value = 0, regardless of RegRdData or forward sources.
  - Else if ExMemRegWrite & ExMemWrAddr == addr: value = ExMemResult (highest priority).
  - Else if MemWbRegWrite & MemWbWrAddr == addr: value = MemWbData.
  - Else: value = RegA/BRdData.
- OpA = forwarded Rs. StoreData = forwarded Rt. OpB = latched AluSrc ? latched Imm : forwarded Rt.
- StallCount increments by 1 on every rising edge where Stall = 1 and Reset = 0. It saturates at 2^CW-1 and never wraps. Flush-only bubbles are not counted.
- No combinational path from Id* to Ex* outputs. Stall is the only output combinational in Id*.

Test Plan:
- Reset then idle: assert Reset 2 cycles with random Id* -> all Ex* = 0, OpA = 0, Stall = 0, StallCount = 0.
- EX/MEM forward: latch Rs=3, Rt=4 with RegARdData=0x11, RegBRdData=0x22; ExMemRegWrite=1, ExMemWrAddr=3, ExMemResult=0xAAAA0001 -> OpA = 0xAAAA0001, OpB = 0x22.
- Priority and $0: EX/MEM and MEM/WB both target 5 (0x1 vs 0x2), Rs=5 -> OpA = 0x1. Rs=0 with both sources targeting 0 -> OpA = 0.
- Load-use: lw to $8 in EX, ID add with Rs=8 -> Stall = 1 for exactly one cycle. Next cycle ExRegWrite = 0 and StallCount = 1. Then add latches with MEM/WB forward 0xDEADBEEF -> OpA = 0xDEADBEEF.
- Flush: Flush=1 with IdRegWrite=1, IdMemWrite=1 -> next cycle ExRegWrite = 0, ExMemWrite = 0, StallCount unchanged.
- Saturation: CW=4, hold hazard for 20 cycles -> StallCount reaches 15 and stays 15. Reset mid-run -> 0 on the next edge.
